// File: rtl/timer.sv
// ---------------------------------------------------------------------------
// timer
//
// Memory-mapped down-counting timer for the picorv32 SoC.
// A programmable prescaler turns the system clock into ticks. A 32-bit
// counter decrements once per tick. When the counter underflows, it raises a
// sticky expiry flag. The counter then either reloads from LOAD
// (auto-reload) or stops and clears its own enable (one-shot).
//
// Register map (word index on reg_addr):
//   0 CTRL     bit0 enable, bit1 auto_reload, bit2 irq_en
//   1 LOAD     reload value
//   2 COUNT    current counter value (writable)
//   3 STATUS   bit0 expired, sticky, write-1-to-clear
//   4 PRESCALE tick every PRESCALE+1 clocks
//   5-7        read 0, writes ignored
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   reg_we    single-cycle full-word write strobe
//   reg_addr  word index (CPU addr[4:2])
//   reg_data  write data
//   reg_q     registered read data for reg_addr, one cycle after the address
//   irq       level interrupt, STATUS.expired & CTRL.irq_en
// ---------------------------------------------------------------------------
module timer #(
    parameter int unsigned PRESCALE_WIDTH = 16,
    parameter int unsigned PRESCALE_RESET = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_we,
    input  logic [2:0]  reg_addr,
    input  logic [31:0] reg_data,
    output logic [31:0] reg_q,
    output logic        irq
);

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_LOAD     = 3'd1;
    localparam logic [2:0] ADDR_COUNT    = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_PRESCALE = 3'd4;

    logic                      ctrl_enable;
    logic                      ctrl_auto_reload;
    logic                      ctrl_irq_en;
    logic [31:0]               load_q;
    logic [31:0]               count_q;
    logic                      expired;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [PRESCALE_WIDTH-1:0] pcnt;

    logic                      wr_ctrl;
    logic                      wr_load;
    logic                      wr_count;
    logic                      wr_status;
    logic                      wr_prescale;
    logic                      tick;
    logic                      expire;
    logic                      pcnt_restart;
    logic [31:0]               prescale_ext;
    logic [31:0]               rd_data;

    // Write decode and tick/expiry qualification.
    // A COUNT write in a tick cycle discards the whole tick. That covers both
    // the decrement and any expiry it would have raised.
    always_comb begin
        wr_ctrl      = reg_we && (reg_addr == ADDR_CTRL);
        wr_load      = reg_we && (reg_addr == ADDR_LOAD);
        wr_count     = reg_we && (reg_addr == ADDR_COUNT);
        wr_status    = reg_we && (reg_addr == ADDR_STATUS);
        wr_prescale  = reg_we && (reg_addr == ADDR_PRESCALE);
        tick         = ctrl_enable && (pcnt == prescale_q);
        expire       = tick && !wr_count && (count_q == 32'd0);
        pcnt_restart = wr_prescale || (wr_ctrl && reg_data[0] && !ctrl_enable);
    end

    // Prescaler counter. It sits at 0 while the timer is disabled. It
    // restarts on a new divisor or on a fresh enable, so the first tick
    // always lands PRESCALE+1 clocks after that write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (pcnt_restart || !ctrl_enable || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PRESCALE_WIDTH'(1);
        end
    end

    // Control register. A one-shot expiry clears enable unless the CPU
    // writes CTRL in that same cycle, in which case the written value wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_enable      <= 1'b0;
            ctrl_auto_reload <= 1'b0;
            ctrl_irq_en      <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_enable      <= reg_data[0];
            ctrl_auto_reload <= reg_data[1];
            ctrl_irq_en      <= reg_data[2];
        end else if (expire && !ctrl_auto_reload) begin
            ctrl_enable      <= 1'b0;
        end
    end

    // Reload value. A LOAD write in a reload cycle does not affect that
    // reload. The counter samples the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q <= '0;
        end else if (wr_load) begin
            load_q <= reg_data;
        end
    end

    // Main counter. It saturates at 0 and never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (wr_count) begin
            count_q <= reg_data;
        end else if (tick) begin
            if (count_q != 32'd0) begin
                count_q <= count_q - 32'd1;
            end else if (ctrl_auto_reload) begin
                count_q <= load_q;
            end
        end
    end

    // Sticky expiry flag. When a set and a clear happen in the same cycle,
    // the set wins so that an expiry is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expired <= 1'b0;
        end else if (expire) begin
            expired <= 1'b1;
        end else if (wr_status && reg_data[0]) begin
            expired <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_q <= PRESCALE_WIDTH'(PRESCALE_RESET);
        end else if (wr_prescale) begin
            prescale_q <= reg_data[PRESCALE_WIDTH-1:0];
        end
    end

    // Read mux. Unused bits and unmapped indices read as zero.
    always_comb begin
        prescale_ext                       = '0;
        prescale_ext[PRESCALE_WIDTH-1:0]   = prescale_q;
        rd_data                            = '0;
        case (reg_addr)
            ADDR_CTRL:     rd_data = {29'd0, ctrl_irq_en, ctrl_auto_reload, ctrl_enable};
            ADDR_LOAD:     rd_data = load_q;
            ADDR_COUNT:    rd_data = count_q;
            ADDR_STATUS:   rd_data = {31'd0, expired};
            ADDR_PRESCALE: rd_data = prescale_ext;
            default:       rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q <= '0;
        end else begin
            reg_q <= rd_data;
        end
    end

    // The IRQ is built only from registers. It therefore drops as soon as
    // rst_n asserts, without waiting for a clock edge.
    assign irq = expired && ctrl_irq_en;

endmodule
